// File: rtl/sipo_frame_ctrl.sv
// Frame sequencer for the SIPO symbol serializer: takes words over valid/ready,
// holds start per word, checks the symbol count, guards each word with a watchdog.
module sipo_frame_ctrl #(
  parameter int SIZE_DATA_IN  = 16,
  parameter int SIZE_DATA_OUT = 2,
  parameter int FRAME_WORDS   = 64,
  parameter int TIMEOUT       = 64
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_frame_start,
  input  logic                             i_abort,
  input  logic                             i_word_valid,
  input  logic [SIZE_DATA_IN-1:0]          i_word_data,
  output logic                             o_word_ready,
  output logic                             o_sipo_start,
  output logic [SIZE_DATA_IN-1:0]          o_sipo_data,
  input  logic                             i_sipo_valid,
  input  logic                             i_sipo_done,
  output logic                             o_busy,
  output logic [$clog2(FRAME_WORDS+1)-1:0] o_word_cnt,
  output logic                             o_frame_done,
  output logic                             o_err_timeout,
  output logic                             o_err_count,
  input  logic                             i_clr_err
);

  localparam int SYMS  = SIZE_DATA_IN / SIZE_DATA_OUT;
  localparam int CNT_W = $clog2(FRAME_WORDS + 1);
  localparam int SYM_W = $clog2(SYMS + 2);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RUN, S_GAP} state_t;

  state_t                  state, state_nxt;
  logic [SIZE_DATA_IN-1:0] data_q;
  logic [CNT_W-1:0]        word_cnt;
  logic [SYM_W-1:0]        sym_cnt;
  logic [WD_W-1:0]         wd_cnt;
  logic [SYM_W:0]          sym_total;
  logic                    err_timeout, err_count;
  logic                    accept, word_done, wd_expire, frame_begin, count_bad;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    word_done   = 1'b0;
    wd_expire   = 1'b0;
    frame_begin = 1'b0;
    case (state)
      S_IDLE: if (i_frame_start) begin
        frame_begin = 1'b1;
        state_nxt   = S_WAIT;
      end
      S_WAIT: if (i_word_valid) begin
        accept    = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (i_sipo_done) begin
          word_done = 1'b1;
          state_nxt = S_GAP;
        end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
          wd_expire = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_GAP:   state_nxt = (word_cnt == CNT_W'(FRAME_WORDS)) ? S_IDLE : S_WAIT;
      default: state_nxt = S_IDLE;
    endcase
    // Abort outranks every other event in the same cycle.
    if (i_abort) begin
      state_nxt   = S_IDLE;
      accept      = 1'b0;
      word_done   = 1'b0;
      wd_expire   = 1'b0;
      frame_begin = 1'b0;
    end
  end

  assign sym_total = {1'b0, sym_cnt} + (SYM_W + 1)'(i_sipo_valid);
  assign count_bad = (sym_total != (SYM_W + 1)'(SYMS));

  // NOTE: the word register is reset too, so the SIPO data bus reads 0 out of reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      data_q      <= '0;
      word_cnt    <= '0;
      sym_cnt     <= '0;
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
      err_count   <= 1'b0;
    end else begin
      if (accept) begin
        data_q  <= i_word_data;
        sym_cnt <= '0;
        wd_cnt  <= '0;
      end else if (state == S_RUN) begin
        if (i_sipo_valid && sym_cnt != SYM_W'(SYMS + 1)) sym_cnt <= sym_cnt + SYM_W'(1);
        if (wd_cnt != WD_W'(TIMEOUT))                     wd_cnt  <= wd_cnt + WD_W'(1);
      end

      if (frame_begin)    word_cnt <= '0;
      else if (word_done) word_cnt <= word_cnt + CNT_W'(1);

      // Setting an error wins over a same-cycle clear.
      err_timeout <= wd_expire | (err_timeout & ~i_clr_err);
      err_count   <= (word_done & count_bad) | (err_count & ~i_clr_err);
    end
  end

  assign o_word_ready  = (state == S_WAIT);
  assign o_sipo_start  = (state == S_RUN);
  assign o_sipo_data   = data_q;
  assign o_busy        = (state != S_IDLE);
  assign o_word_cnt    = word_cnt;
  assign o_frame_done  = (state == S_GAP) && (word_cnt == CNT_W'(FRAME_WORDS));
  assign o_err_timeout = err_timeout;
  assign o_err_count   = err_count;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed-plus-random bench for sipo_frame_ctrl; a transaction-level SIPO model
// and frame bookkeeping supply every expected value.
module tb_sipo_frame_ctrl;

  localparam int DIN  = 16;
  localparam int DOUT = 2;
  localparam int FW   = 4;
  localparam int TO   = 32;
  localparam int SYMS = DIN / DOUT;

  logic            i_clk = 1'b0;
  logic            i_rst, i_frame_start, i_abort, i_word_valid;
  logic [DIN-1:0]  i_word_data;
  logic            o_word_ready, o_sipo_start;
  logic [DIN-1:0]  o_sipo_data;
  logic            i_sipo_valid, i_sipo_done;
  logic            o_busy;
  logic [$clog2(FW+1)-1:0] o_word_cnt;
  logic            o_frame_done, o_err_timeout, o_err_count, i_clr_err;

  int vectors     = 0;
  int miscompares = 0;
  int exp_cnt;
  bit exp_err_cnt, exp_err_to;

  sipo_frame_ctrl #(
    .SIZE_DATA_IN (DIN),
    .SIZE_DATA_OUT(DOUT),
    .FRAME_WORDS  (FW),
    .TIMEOUT      (TO)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_frame_start(i_frame_start),
    .i_abort      (i_abort),
    .i_word_valid (i_word_valid),
    .i_word_data  (i_word_data),
    .o_word_ready (o_word_ready),
    .o_sipo_start (o_sipo_start),
    .o_sipo_data  (o_sipo_data),
    .i_sipo_valid (i_sipo_valid),
    .i_sipo_done  (i_sipo_done),
    .o_busy       (o_busy),
    .o_word_cnt   (o_word_cnt),
    .o_frame_done (o_frame_done),
    .o_err_timeout(o_err_timeout),
    .o_err_count  (o_err_count),
    .i_clr_err    (i_clr_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"},   o_sipo_start,  0);
    check({tag, "_data"},    o_sipo_data,   0);
    check({tag, "_ready"},   o_word_ready,  0);
    check({tag, "_busy"},    o_busy,        0);
    check({tag, "_cnt"},     o_word_cnt,    0);
    check({tag, "_fdone"},   o_frame_done,  0);
    check({tag, "_err_to"},  o_err_timeout, 0);
    check({tag, "_err_cnt"}, o_err_count,   0);
  endtask

  task automatic start_frame();
    check("idle_before_start", o_busy, 0);
    i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
    exp_cnt = 0;
    check("wait_ready", o_word_ready, 1);
    check("wait_cnt_zero", o_word_cnt, 0);
  endtask

  // One word through the SIPO model: optional lead-in delay, nvalid symbols,
  // done either with the last symbol or one cycle later.
  task automatic run_word(input logic [DIN-1:0] w, input int nvalid, input bit abort_on_done);
    int delay, done_cyc;
    bit with_last;
    delay     = $urandom_range(0, 3);
    with_last = 1'($urandom_range(0, 1));
    done_cyc  = delay + nvalid + (with_last ? 0 : 1);
    check("ready_before_word", o_word_ready, 1);
    check("start_low_in_wait", o_sipo_start, 0);
    i_word_valid = 1'b1;
    i_word_data  = w;
    tick();
    i_word_valid = 1'b0;
    i_word_data  = DIN'($urandom);
    check("start_after_accept", o_sipo_start, 1);
    check("data_after_accept", o_sipo_data, w);
    check("ready_low_in_run", o_word_ready, 0);
    for (int c = 1; c <= done_cyc; c++) begin
      i_sipo_valid = (c > delay) && (c <= delay + nvalid);
      i_sipo_done  = (c == done_cyc);
      i_abort      = abort_on_done && (c == done_cyc);
      check("start_held", o_sipo_start, 1);
      tick();
    end
    i_sipo_valid = 1'b0;
    i_sipo_done  = 1'b0;
    i_abort      = 1'b0;
    if (abort_on_done) begin
      check("abort_busy", o_busy, 0);
      check("abort_start", o_sipo_start, 0);
      check("abort_cnt", o_word_cnt, exp_cnt);
      check("abort_fdone", o_frame_done, 0);
      return;
    end
    exp_cnt++;
    if (nvalid != SYMS) exp_err_cnt = 1'b1;
    check("gap_start_low", o_sipo_start, 0);
    check("gap_busy", o_busy, 1);
    check("gap_cnt", o_word_cnt, exp_cnt);
    check("gap_fdone", o_frame_done, exp_cnt == FW);
    check("gap_err_cnt", o_err_count, exp_err_cnt);
    check("gap_err_to", o_err_timeout, exp_err_to);
    tick();
    check("fdone_one_cycle", o_frame_done, 0);
    if (exp_cnt == FW) check("idle_after_frame", o_busy, 0);
    else               check("ready_after_gap", o_word_ready, 1);
  endtask

  task automatic timeout_word(input logic [DIN-1:0] w);
    int delay, high;
    delay = $urandom_range(0, 3);
    high  = 0;
    i_word_valid = 1'b1;
    i_word_data  = w;
    tick();
    i_word_valid = 1'b0;
    while (o_sipo_start && high < 100) begin
      i_sipo_valid = (high >= delay) && (high < delay + SYMS);
      high++;
      tick();
    end
    i_sipo_valid = 1'b0;
    exp_err_to = 1'b1;
    check("timeout_start_cycles", high, TO);
    check("timeout_err", o_err_timeout, 1);
    check("timeout_idle", o_busy, 0);
    check("timeout_no_fdone", o_frame_done, 0);
    check("timeout_cnt_hold", o_word_cnt, exp_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    i_rst = 1'b1;
    i_frame_start = 1'b0; i_abort = 1'b0; i_word_valid = 1'b0; i_word_data = '0;
    i_sipo_valid = 1'b0; i_sipo_done = 1'b0; i_clr_err = 1'b0;
    exp_cnt = 0; exp_err_cnt = 1'b0; exp_err_to = 1'b0;
    #3;
    check_all_zero("reset");
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    tick();
    check("idle_ready_low", o_word_ready, 0);

    // Directed frame, back-to-back words.
    start_frame();
    run_word(16'hAAAA, SYMS, 1'b0);
    run_word(16'h1234, SYMS, 1'b0);
    run_word(16'hFFFF, SYMS, 1'b0);
    run_word(16'h0000, SYMS, 1'b0);
    check("frame1_no_err_cnt", o_err_count, 0);
    check("frame1_no_err_to", o_err_timeout, 0);

    // Word withheld in WAIT: no start, no watchdog.
    start_frame();
    for (int i = 0; i < 10; i++) begin
      check("withheld_ready", o_word_ready, 1);
      check("withheld_start", o_sipo_start, 0);
      tick();
    end
    check("withheld_no_timeout", o_err_timeout, 0);
    for (int i = 0; i < FW; i++) run_word(DIN'($urandom), SYMS, 1'b0);

    // SIPO never signals done on the second word.
    start_frame();
    run_word(DIN'($urandom), SYMS, 1'b0);
    timeout_word(DIN'($urandom));
    repeat (3) tick();
    check("timeout_sticky", o_err_timeout, 1);
    i_clr_err = 1'b1;
    tick();
    i_clr_err = 1'b0;
    exp_err_to = 1'b0;
    check("timeout_cleared", o_err_timeout, 0);

    // Short word: count error, frame still completes.
    start_frame();
    run_word(DIN'($urandom), SYMS, 1'b0);
    run_word(DIN'($urandom), SYMS - 1, 1'b0);
    run_word(DIN'($urandom), SYMS, 1'b0);
    run_word(DIN'($urandom), SYMS, 1'b0);
    check("count_err_sticky", o_err_count, 1);
    i_clr_err = 1'b1;
    tick();
    i_clr_err = 1'b0;
    exp_err_cnt = 1'b0;
    check("count_err_cleared", o_err_count, 0);

    // Abort coincident with done of word 2, then a clean frame.
    start_frame();
    run_word(DIN'($urandom), SYMS, 1'b0);
    run_word(DIN'($urandom), SYMS, 1'b1);
    repeat (3) tick();
    check("abort_cnt_holds", o_word_cnt, 1);
    check("abort_no_fdone", o_frame_done, 0);
    start_frame();
    for (int i = 0; i < FW; i++) run_word(DIN'($urandom), SYMS, 1'b0);

    // Ignored frame_start while busy, then reset during RUN of word 3.
    start_frame();
    run_word(DIN'($urandom), SYMS, 1'b0);
    run_word(DIN'($urandom), SYMS, 1'b0);
    i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
    check("busy_start_ignored_cnt", o_word_cnt, 2);
    check("busy_start_ignored_rdy", o_word_ready, 1);
    i_word_valid = 1'b1;
    i_word_data  = DIN'($urandom);
    tick();
    i_word_valid = 1'b0;
    check("word3_running", o_sipo_start, 1);
    tick();
    #2;
    i_rst = 1'b1;
    #1;
    check_all_zero("mid_run_reset");
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    tick();
    start_frame();
    for (int i = 0; i < FW; i++) run_word(DIN'($urandom), SYMS, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
